mem_arbiter: RTL and testbench

Two-port arbiter that shares the single line-fill memory port (request/finish/partial/replace protocol) between the instruction-cache and data-cache refill engines. It sits between both caches and the memory or its simulation model. It grants one requester at a time, registers that requester's command onto the memory side, and returns finish and partial only to the owner. It also routes each line-replace pulse to the cache(s) that requested that line.

---
 rtl/mem_arbiter_pkg.sv | 12 +
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings, port indices and widths for the line-fill arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;
  localparam logic ARB_PORT_I = 1'b0;
  localparam logic ARB_PORT_D = 1'b1;
  localparam int LINE_W = 12;
  localparam int BURST_W = 4;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select; MEM_ARB_DPRIO_EN gives d-priority with a burst cap, else round-robin
module mem_arb_pick
  import mem_arbiter_pkg::*;
`ifdef MEM_ARB_DPRIO_EN
  #(parameter int MAX_BURST = 4)
`endif
(
  input  logic               i_req_i,
  input  logic               i_req_d,
`ifdef MEM_ARB_DPRIO_EN
  input  logic [BURST_W-1:0] i_burst_cnt,
`else
  input  logic               i_rr_ptr,
`endif
  output logic               o_valid,
  output logic               o_port
);
  logic w_tie_port;
`ifdef MEM_ARB_DPRIO_EN
  assign w_tie_port = (i_burst_cnt >= BURST_W'(MAX_BURST)) ? ARB_PORT_I : ARB_PORT_D;
`else
  assign w_tie_port = i_rr_ptr;
`endif
  assign o_valid = i_req_i | i_req_d;
  assign o_port  = (i_req_i & i_req_d) ? w_tie_port : (i_req_d ? ARB_PORT_D : ARB_PORT_I);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-fill memory port between i- and d-cache refill engines (option: MEM_ARB_DPRIO_EN)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         i_request,
  input  logic         i_rwn,
  input  logic [15:0]  i_addr,
  input  logic [15:0]  i_commit,
  input  logic [127:0] i_wdata,
  output logic         i_finish,
  output logic         i_partial,
  output logic         i_replace,
  input  logic         d_request,
  input  logic         d_rwn,
  input  logic [15:0]  d_addr,
  input  logic [15:0]  d_commit,
  input  logic [127:0] d_wdata,
  output logic         d_finish,
  output logic         d_partial,
  output logic         d_replace,
  output logic         mem_request,
  output logic         mem_rwn,
  output logic [15:0]  mem_addr,
  output logic [15:0]  mem_commit,
  output logic [127:0] mem_write_data,
  input  logic         mem_finish,
  input  logic         mem_partial,
  input  logic         mem_replace,
  input  logic [4:0]   mem_replace_set,
  input  logic [6:0]   mem_replace_tag
);
  arb_state_t r_state, w_next;
  logic w_gnt, w_port, w_take, w_win_rwn;
  logic r_mem_req, r_mem_rwn;
  logic [15:0] r_mem_addr, r_mem_commit;
  logic [127:0] r_mem_wdata;
  logic [LINE_W-1:0] r_line_i, r_line_d, w_rep_line;
  logic r_lv_i, r_lv_d, w_own_i, w_own_d;
`ifdef MEM_ARB_DPRIO_EN
  logic [BURST_W-1:0] r_burst_cnt;
  mem_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .i_req_i(i_request), .i_req_d(d_request), .i_burst_cnt(r_burst_cnt),
    .o_valid(w_gnt), .o_port(w_port)
  );
  // burst_cnt counts d-grants made while i waits; any i-grant or idle i_request clears it
  always_ff @(posedge sys_clk)
    if (sys_rst || !i_request) r_burst_cnt <= '0;
    else if (w_take) r_burst_cnt <= (w_port == ARB_PORT_D) ? r_burst_cnt + 1'b1 : '0;
`else
  logic r_rr_ptr;
  mem_arb_pick u_pick (
    .i_req_i(i_request), .i_req_d(d_request), .i_rr_ptr(r_rr_ptr),
    .o_valid(w_gnt), .o_port(w_port)
  );
  // round-robin pointer moves to the loser after every grant
  always_ff @(posedge sys_clk)
    if (sys_rst) r_rr_ptr <= ARB_PORT_I;
    else if (w_take) r_rr_ptr <= ~w_port;
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_max_burst_out_of_range
  end
`endif
  assign w_take    = (r_state == ARB_IDLE) && w_gnt;
  assign w_win_rwn = w_port ? d_rwn : i_rwn;
  // state register
  always_ff @(posedge sys_clk)
    r_state <= sys_rst ? ARB_IDLE : w_next;
  // next state: grant from IDLE, leave BUSY on finish or when the owner withdraws
  always_comb
    w_next = (r_state == ARB_IDLE)   ? (w_gnt ? (w_port ? ARB_BUSY_D : ARB_BUSY_I) : ARB_IDLE) :
             (r_state == ARB_BUSY_I) ? ((!i_request || mem_finish) ? ARB_IDLE : ARB_BUSY_I) :
                                       ((!d_request || mem_finish) ? ARB_IDLE : ARB_BUSY_D);
  // memory command registers latch the winner once and hold through BUSY
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      r_mem_req    <= 1'b0;
      r_mem_rwn    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_commit <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_mem_req <= (w_next != ARB_IDLE);
      if (w_take) begin
        r_mem_rwn    <= w_win_rwn;
        r_mem_addr   <= w_port ? d_addr : i_addr;
        r_mem_commit <= w_port ? d_commit : i_commit;
        r_mem_wdata  <= w_port ? d_wdata : i_wdata;
      end
    end
  // line records remember the last refill line each port was granted; writebacks leave them alone
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      r_lv_i   <= 1'b0;
      r_lv_d   <= 1'b0;
      r_line_i <= '0;
      r_line_d <= '0;
    end else if (w_take && w_win_rwn) begin
      if (w_port == ARB_PORT_D) begin
        r_lv_d   <= 1'b1;
        r_line_d <= d_addr[15:4];
      end else begin
        r_lv_i   <= 1'b1;
        r_line_i <= i_addr[15:4];
      end
    end
  // outputs: finish/partial only to a still-requesting owner, replace to every matching recorded line
  always_comb begin
    w_own_i    = !sys_rst && (r_state == ARB_BUSY_I) && i_request;
    w_own_d    = !sys_rst && (r_state == ARB_BUSY_D) && d_request;
    w_rep_line = {mem_replace_tag, mem_replace_set};
    i_finish   = w_own_i && mem_finish;
    i_partial  = w_own_i && mem_partial;
    d_finish   = w_own_d && mem_finish;
    d_partial  = w_own_d && mem_partial;
    i_replace  = !sys_rst && mem_replace && r_lv_i && (r_line_i == w_rep_line);
    d_replace  = !sys_rst && mem_replace && r_lv_d && (r_line_d == w_rep_line);
  end
  assign mem_request    = r_mem_req;
  assign mem_rwn        = r_mem_rwn;
  assign mem_addr       = r_mem_addr;
  assign mem_commit     = r_mem_commit;
  assign mem_write_data = r_mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int MAXB = 4;
  logic sys_clk = 1'b0, sys_rst;
  logic i_request, i_rwn, d_request, d_rwn;
  logic [15:0] i_addr, i_commit, d_addr, d_commit;
  logic [127:0] i_wdata, d_wdata;
  logic i_finish, i_partial, i_replace, d_finish, d_partial, d_replace;
  logic mem_request, mem_rwn;
  logic [15:0] mem_addr, mem_commit;
  logic [127:0] mem_write_data;
  logic mem_finish, mem_partial, mem_replace;
  logic [4:0] mem_replace_set;
  logic [6:0] mem_replace_tag;
  int checks = 0, errors = 0;
  bit m_req[2], m_rwn[2], m_lv[2];
  logic [15:0] m_addr[2], m_commit[2];
  logic [127:0] m_wdata[2];
  logic [11:0] m_line[2];
  int m_ptr, m_cnt;

  mem_arbiter #(.MAX_BURST(MAXB)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .i_request(i_request), .i_rwn(i_rwn), .i_addr(i_addr), .i_commit(i_commit), .i_wdata(i_wdata),
    .i_finish(i_finish), .i_partial(i_partial), .i_replace(i_replace),
    .d_request(d_request), .d_rwn(d_rwn), .d_addr(d_addr), .d_commit(d_commit), .d_wdata(d_wdata),
    .d_finish(d_finish), .d_partial(d_partial), .d_replace(d_replace),
    .mem_request(mem_request), .mem_rwn(mem_rwn), .mem_addr(mem_addr), .mem_commit(mem_commit),
    .mem_write_data(mem_write_data), .mem_finish(mem_finish), .mem_partial(mem_partial),
    .mem_replace(mem_replace), .mem_replace_set(mem_replace_set), .mem_replace_tag(mem_replace_tag)
  );

  always #5 sys_clk = ~sys_clk;

  task step();
    @(posedge sys_clk);
    #1;
  endtask

  task do_reset();
    sys_rst = 1'b1;
    i_request = 0; i_rwn = 0; i_addr = 0; i_commit = 0; i_wdata = 0;
    d_request = 0; d_rwn = 0; d_addr = 0; d_commit = 0; d_wdata = 0;
    mem_finish = 0; mem_partial = 0; mem_replace = 0; mem_replace_set = 0; mem_replace_tag = 0;
    step();
    step();
    sys_rst = 1'b0;
  endtask

  task single_read(input bit p, input logic [15:0] a);
    if (p) begin d_request = 1; d_rwn = 1; d_addr = a; end
    else begin i_request = 1; i_rwn = 1; i_addr = a; end
    step();
    mem_finish = 1;
    step();
    mem_finish = 0; i_request = 0; d_request = 0;
    step();
  endtask

  task test_reset();
    do_reset();
    checks++;
    if ({mem_request, mem_rwn, mem_addr, mem_commit, mem_write_data} !== '0) begin
      errors++; $display("FAIL reset_mem got req=%b addr=%h commit=%h want all 0", mem_request, mem_addr, mem_commit);
    end
    checks++;
    if ({i_finish, i_partial, i_replace, d_finish, d_partial, d_replace} !== 6'b0) begin
      errors++; $display("FAIL reset_ports got %b want 000000", {i_finish, i_partial, i_replace, d_finish, d_partial, d_replace});
    end
  endtask

  task test_i_read();
    logic [127:0] w;
    do_reset();
    w = {$urandom, $urandom, $urandom, $urandom};
    i_request = 1; i_rwn = 1; i_addr = 16'h0120; i_commit = 16'h0001; i_wdata = w;
    step();
    checks++;
    if (mem_request !== 1'b1 || mem_addr !== 16'h0120 || mem_commit !== 16'h0001 || mem_rwn !== 1'b1 || mem_write_data !== w) begin
      errors++; $display("FAIL i_read_cmd got req=%b addr=%h commit=%h rwn=%b want 1 0120 0001 1", mem_request, mem_addr, mem_commit, mem_rwn);
    end
    step();
    checks++;
    if (mem_request !== 1'b1 || mem_addr !== 16'h0120) begin
      errors++; $display("FAIL i_read_hold got req=%b addr=%h want 1 0120", mem_request, mem_addr);
    end
    mem_finish = 1; mem_partial = 1;
    #1;
    checks++;
    if ({i_finish, i_partial, d_finish, d_partial} !== 4'b1100) begin
      errors++; $display("FAIL i_read_route got %b want 1100", {i_finish, i_partial, d_finish, d_partial});
    end
    step();
    mem_finish = 0; mem_partial = 0; i_request = 0;
    checks++;
    if (mem_request !== 1'b0) begin
      errors++; $display("FAIL i_read_idle got req=%b want 0", mem_request);
    end
    step();
  endtask

  task test_both();
    logic [127:0] w;
    do_reset();
    w = {$urandom, $urandom, $urandom, $urandom};
    i_request = 1; i_rwn = 1; i_addr = 16'h0450;
    d_request = 1; d_rwn = 0; d_addr = 16'h2A30; d_commit = 16'hFFFF; d_wdata = w;
    step();
    checks++;
    if (mem_request !== 1'b1 || mem_addr !== 16'h0450) begin
      errors++; $display("FAIL both_i_first got req=%b addr=%h want 1 0450", mem_request, mem_addr);
    end
    step();
    mem_finish = 1;
    #1;
    checks++;
    if (i_finish !== 1'b1 || d_finish !== 1'b0) begin
      errors++; $display("FAIL both_i_finish got i=%b d=%b want 1 0", i_finish, d_finish);
    end
    step();
    i_request = 0; mem_finish = 0;
    checks++;
    if (mem_request !== 1'b0) begin
      errors++; $display("FAIL both_dead_cycle got req=%b want 0", mem_request);
    end
    step();
    checks++;
    if (mem_request !== 1'b1 || mem_addr !== 16'h2A30 || mem_rwn !== 1'b0 || mem_commit !== 16'hFFFF || mem_write_data !== w) begin
      errors++; $display("FAIL both_d_cmd got req=%b addr=%h rwn=%b commit=%h want 1 2a30 0 ffff", mem_request, mem_addr, mem_rwn, mem_commit);
    end
    mem_finish = 1;
    #1;
    checks++;
    if (d_finish !== 1'b1 || i_finish !== 1'b0) begin
      errors++; $display("FAIL both_d_finish got d=%b i=%b want 1 0", d_finish, i_finish);
    end
    step();
    d_request = 0; mem_finish = 0;
    step();
  endtask

  task test_replace();
    do_reset();
    single_read(1'b1, 16'h2A30);
    single_read(1'b0, 16'h0450);
    mem_replace = 1; mem_replace_tag = 7'h15; mem_replace_set = 5'h03;
    #1;
    checks++;
    if (d_replace !== 1'b1 || i_replace !== 1'b0) begin
      errors++; $display("FAIL replace_d_only got d=%b i=%b want 1 0", d_replace, i_replace);
    end
    mem_replace = 0;
    single_read(1'b0, 16'h2A3F);
    mem_replace = 1;
    #1;
    checks++;
    if (d_replace !== 1'b1 || i_replace !== 1'b1) begin
      errors++; $display("FAIL replace_both got d=%b i=%b want 1 1", d_replace, i_replace);
    end
    mem_replace_set = 5'h04;
    #1;
    checks++;
    if (d_replace !== 1'b0 || i_replace !== 1'b0) begin
      errors++; $display("FAIL replace_miss got d=%b i=%b want 0 0", d_replace, i_replace);
    end
    mem_replace = 0;
    step();
  endtask

  task test_abort();
    do_reset();
    i_request = 1; i_rwn = 1; i_addr = 16'h0100;
    d_request = 1; d_rwn = 1; d_addr = 16'h0200;
    step();
    checks++;
    if (mem_request !== 1'b1 || mem_addr !== 16'h0100) begin
      errors++; $display("FAIL abort_grant_i got req=%b addr=%h want 1 0100", mem_request, mem_addr);
    end
    i_request = 0; mem_finish = 1;
    #1;
    checks++;
    if (i_finish !== 1'b0 || d_finish !== 1'b0) begin
      errors++; $display("FAIL abort_discard got i=%b d=%b want 0 0", i_finish, d_finish);
    end
    step();
    mem_finish = 0;
    checks++;
    if (mem_request !== 1'b0) begin
      errors++; $display("FAIL abort_drop got req=%b want 0", mem_request);
    end
    step();
    checks++;
    if (mem_request !== 1'b1 || mem_addr !== 16'h0200) begin
      errors++; $display("FAIL abort_then_d got req=%b addr=%h want 1 0200", mem_request, mem_addr);
    end
    mem_finish = 1;
    step();
    d_request = 0; mem_finish = 0;
    step();
  endtask

  task test_reset_busy();
    do_reset();
    d_request = 1; d_rwn = 1; d_addr = 16'h2A30;
    step();
    checks++;
    if (mem_request !== 1'b1 || mem_addr !== 16'h2A30) begin
      errors++; $display("FAIL rstbusy_grant got req=%b addr=%h want 1 2a30", mem_request, mem_addr);
    end
    step();
    sys_rst = 1; mem_finish = 1;
    #1;
    checks++;
    if (d_finish !== 1'b0) begin
      errors++; $display("FAIL rstbusy_finish got %b want 0", d_finish);
    end
    step();
    checks++;
    if (mem_request !== 1'b0) begin
      errors++; $display("FAIL rstbusy_req got %b want 0", mem_request);
    end
    sys_rst = 0; mem_finish = 0; d_request = 0;
    step();
    mem_replace = 1; mem_replace_tag = 7'h15; mem_replace_set = 5'h03;
    #1;
    checks++;
    if (d_replace !== 1'b0 || i_replace !== 1'b0) begin
      errors++; $display("FAIL rstbusy_replace got d=%b i=%b want 0 0", d_replace, i_replace);
    end
    mem_replace = 0;
    step();
  endtask

`ifdef MEM_ARB_DPRIO_EN
  task test_dprio_burst();
    logic [15:0] exp;
    do_reset();
    i_request = 1; i_rwn = 1; i_addr = 16'h0100;
    d_request = 1; d_rwn = 1; d_addr = 16'h0200;
    for (int k = 0; k < 2 * (MAXB + 1); k++) begin
      step();
      exp = (k % (MAXB + 1) == MAXB) ? 16'h0100 : 16'h0200;
      checks++;
      if (mem_request !== 1'b1 || mem_addr !== exp) begin
        errors++; $display("FAIL dprio_seq grant %0d got req=%b addr=%h want 1 %h", k, mem_request, mem_addr, exp);
      end
      mem_finish = 1;
      step();
      mem_finish = 0;
    end
    i_request = 0; d_request = 0;
    step();
  endtask
`endif

  task new_req(input int p);
    m_req[p] = 1;
    m_rwn[p] = 1'($urandom_range(1));
    m_addr[p] = 16'($urandom);
    m_commit[p] = 16'($urandom);
    m_wdata[p] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task apply();
    i_request = m_req[0]; i_rwn = m_rwn[0]; i_addr = m_addr[0]; i_commit = m_commit[0]; i_wdata = m_wdata[0];
    d_request = m_req[1]; d_rwn = m_rwn[1]; d_addr = m_addr[1]; d_commit = m_commit[1]; d_wdata = m_wdata[1];
  endtask

  task test_random();
    int w, lat;
    logic [11:0] ln;
    logic exp_i, exp_d;
    do_reset();
    m_ptr = 0; m_cnt = 0;
    for (int p = 0; p < 2; p++) begin
      m_req[p] = 0; m_lv[p] = 0; m_line[p] = 0; m_rwn[p] = 0; m_addr[p] = 0; m_commit[p] = 0; m_wdata[p] = 0;
    end
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < 2; p++) if (!m_req[p] && $urandom_range(1) == 1) new_req(p);
      if (!m_req[0] && !m_req[1]) new_req(int'($urandom_range(1)));
      apply();
`ifdef MEM_ARB_DPRIO_EN
      w = (m_req[0] && m_req[1]) ? ((m_cnt >= MAXB) ? 0 : 1) : (m_req[1] ? 1 : 0);
      m_cnt = (w == 1 && m_req[0]) ? m_cnt + 1 : 0;
`else
      w = (m_req[0] && m_req[1]) ? m_ptr : (m_req[1] ? 1 : 0);
`endif
      m_ptr = 1 - w;
      step();
      checks++;
      if (mem_request !== 1'b1 || mem_addr !== m_addr[w] || mem_rwn !== m_rwn[w] || mem_commit !== m_commit[w] || mem_write_data !== m_wdata[w]) begin
        errors++; $display("FAIL rand_cmd txn %0d got req=%b addr=%h rwn=%b want 1 %h %b (port %0d)", n, mem_request, mem_addr, mem_rwn, m_addr[w], m_rwn[w], w);
      end
      if (m_rwn[w]) begin m_line[w] = m_addr[w][15:4]; m_lv[w] = 1; end
      lat = int'($urandom_range(3));
      for (int c = 0; c < lat; c++) begin
        ln = ($urandom_range(1) == 1) ? m_line[$urandom_range(1)] : 12'($urandom);
        mem_replace = 1'($urandom_range(1));
        {mem_replace_tag, mem_replace_set} = ln;
        #1;
        exp_i = mem_replace && m_lv[0] && (m_line[0] == ln);
        exp_d = mem_replace && m_lv[1] && (m_line[1] == ln);
        checks++;
        if (i_replace !== exp_i || d_replace !== exp_d) begin
          errors++; $display("FAIL rand_replace line %h got i=%b d=%b want %b %b", ln, i_replace, d_replace, exp_i, exp_d);
        end
        step();
      end
      mem_replace = 0; mem_finish = 1; mem_partial = 1'($urandom_range(1));
      #1;
      checks++;
      if ((w == 0 && {i_finish, i_partial, d_finish, d_partial} !== {1'b1, mem_partial, 2'b00}) ||
          (w == 1 && {i_finish, i_partial, d_finish, d_partial} !== {2'b00, 1'b1, mem_partial})) begin
        errors++; $display("FAIL rand_finish txn %0d port %0d got %b partial_in=%b", n, w, {i_finish, i_partial, d_finish, d_partial}, mem_partial);
      end
      step();
      mem_finish = 0; mem_partial = 0; m_req[w] = 0;
      apply();
      checks++;
      if (mem_request !== 1'b0) begin
        errors++; $display("FAIL rand_idle txn %0d got req=%b want 0", n, mem_request);
      end
    end
    m_req[0] = 0; m_req[1] = 0;
    apply();
    step();
  endtask

  initial begin
    test_reset();
    test_i_read();
`ifdef MEM_ARB_DPRIO_EN
    test_dprio_burst();
`else
    test_both();
    test_abort();
`endif
    test_replace();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
